// File: rtl/axis_pattern_pkg.sv
// Shared types and constants for the AXI4-Stream pattern source.
package axis_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } gen_state_e;

  localparam logic            MODE_COUNTER = 1'b0;
  localparam logic            MODE_LFSR    = 1'b1;
  localparam logic [31:0]     LFSR_POLY    = 32'h8020_0003;

  // Right-shifting Galois step: the bit shifted out of bit 0 re-enters at bit 31
  // and toggles the remaining taps of the polynomial.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ ({32{s[0]}} & {LFSR_POLY[31:1], 1'b0});
  endfunction

endpackage

// File: rtl/axis_pattern_source_if.sv
// AXI4-Stream beat bundle between the pattern source and its consumer.
interface axis_pattern_source_if #(parameter int DATA_SIZE = 32);
  logic [DATA_SIZE-1:0]   tdata;
  logic [DATA_SIZE/8-1:0] tstrb;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, tstrb, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO; read data holds its last value while empty.
module axis_sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   level_q;
  logic [WIDTH-1:0]      hold_q;
  logic                  wr_ok, rd_ok;

  // Full comes from the registered level, so a same-cycle read never frees a slot for a write.
  assign full_o  = (level_q == DEPTH);
  assign empty_o = (level_q == '0);
  assign wr_ok   = wr_en_i & ~full_o;
  assign rd_ok   = rd_en_i & ~empty_o;
  assign level_o = level_q;

  assign rd_data_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_pattern_source.sv
// Packetising counter/LFSR pattern generator feeding an FWFT FIFO on the m00 AXI-Stream master.
// Define AXIS_PATTERN_LFSR_EN to build the LFSR pattern and honour cfg_mode.
module axis_pattern_source
  import axis_pattern_pkg::*;
#(
  parameter int          DATA_SIZE  = 32,
  parameter int          ADDR_WIDTH = 12,
  parameter int          LEN_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  m00_axis_enable,
  input  logic                  cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  axis_pattern_source_if.master m00_axis,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic [31:0]           pkt_count
);

  gen_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, idx_q, idx_d;
  logic [DATA_SIZE-1:0] cnt_q, pattern;
  logic [31:0]          pkt_count_q;
  logic                 fifo_full, fifo_empty, wr_en, beat_last;
  logic [DATA_SIZE:0]   rd_data;
  logic [LEN_WIDTH-1:0] cfg_len_eff;

  assign cfg_len_eff = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign beat_last   = (idx_q == len_q - 1'b1);

`ifdef AXIS_PATTERN_LFSR_EN
  localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  logic        mode_q, mode_d;
  logic [31:0] lfsr_q;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      lfsr_q <= SEED;
      mode_q <= MODE_COUNTER;
    end else begin
      mode_q <= mode_d;
      if (wr_en) lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign pattern = (mode_q == MODE_LFSR) ? DATA_SIZE'(lfsr_q) : cnt_q;
`else
  logic [32:0] cfg_unused;
  assign cfg_unused = {cfg_mode, LFSR_SEED};
  assign pattern    = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
`ifdef AXIS_PATTERN_LFSR_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m00_axis_enable) begin
          state_d = ST_RUN;
          len_d   = cfg_len_eff;
          idx_d   = '0;
`ifdef AXIS_PATTERN_LFSR_EN
          mode_d  = cfg_mode;
`endif
        end
      end
      ST_RUN, ST_FINISH: begin
        wr_en = ~fifo_full;
        if (wr_en && beat_last) begin
          // Packet boundary: chain straight into the next packet only if still running.
          if (state_q == ST_RUN && m00_axis_enable) begin
            len_d = cfg_len_eff;
            idx_d = '0;
`ifdef AXIS_PATTERN_LFSR_EN
            mode_d = cfg_mode;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (wr_en) idx_d = idx_q + 1'b1;
          if (!m00_axis_enable) state_d = ST_FINISH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_WIDTH'(1);
      idx_q       <= '0;
      cnt_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      if (wr_en) cnt_q <= cnt_q + 1'b1;
      if (m00_axis.tvalid && m00_axis.tready && m00_axis.tlast)
        pkt_count_q <= pkt_count_q + 1'b1;
    end
  end

  axis_sync_fifo #(
    .WIDTH      (DATA_SIZE + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (m00_axis_aclk),
    .rst_ni    (m00_axis_aresetn),
    .wr_en_i   (wr_en),
    .wr_data_i ({beat_last, pattern}),
    .rd_en_i   (m00_axis.tready),
    .rd_data_o (rd_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .level_o   (fifo_level)
  );

  assign m00_axis.tvalid = ~fifo_empty;
  assign m00_axis.tdata  = rd_data[DATA_SIZE-1:0];
  assign m00_axis.tlast  = rd_data[DATA_SIZE];
  assign m00_axis.tstrb  = {(DATA_SIZE/8){~fifo_empty}};
  assign pkt_count       = pkt_count_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Randomised self-checking bench: accepted beats are compared with a packet-level model.
module tb_axis_pattern_source;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [LW-1:0] len = 16'd4;
  logic [AW:0]   level;
  logic [31:0]   pkt_count;

  axis_pattern_source_if #(.DATA_SIZE(DW)) axis ();

  axis_pattern_source #(
    .DATA_SIZE(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .LFSR_SEED(32'h1)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .m00_axis_enable  (enable),
    .cfg_mode         (mode),
    .cfg_pkt_len      (len),
    .m00_axis         (axis),
    .fifo_level       (level),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] exp_base = '0;
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  int            obs_cyc[$];

  // Record every beat accepted downstream, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
      obs_data.push_back(axis.tdata);
      obs_last.push_back(axis.tlast);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_base = '0;
    clear_obs();
  endtask

  // Stop the generator, accept everything and wait until the output stays quiet.
  task automatic drain(output bit ok);
    int quiet = 0;
    enable = 1'b0; axis.tready = 1'b1; ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (axis.tvalid === 1'b0 && level === '0) quiet++; else quiet = 0;
      if (quiet >= 8) ok = 1'b1;
    end
  endtask

  task automatic wait_beats(input int n, output bit ok);
    ok = 1'b1;
    for (int t = 0; obs_data.size() < n; t++) begin
      if (t > 300) begin ok = 1'b0; break; end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b need 0", axis.tvalid); end
    n_checks++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b need 0", axis.tlast); end
    n_checks++; if (axis.tstrb !== 4'h0) begin n_fail++; $display("FAIL reset_tstrb: got %h need 0", axis.tstrb); end
    n_checks++; if (axis.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h need 0", axis.tdata); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d need 0", level); end
    n_checks++; if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d need 0", pkt_count); end
  endtask

  task automatic test_basic();
    bit ok; int n; logic [31:0] pc0; logic [DW-1:0] base;
    clear_obs(); base = exp_base; pc0 = pkt_count;
    len = 16'd4; mode = 1'b0; axis.tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_tvalid_edge0: got %b need 0", axis.tvalid); end
    @(negedge clk);
    n_checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== base) begin n_fail++; $display("FAIL basic_first_beat: got v=%b d=%h need v=1 d=%h", axis.tvalid, axis.tdata, base); end
    wait_beats(8, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_wait: got %0d beats need 8", obs_data.size()); end
    #1 enable = 1'b0;
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_drain: got busy need idle"); end
    n = obs_data.size();
    n_checks++; if (n % 4 != 0 || n < 8) begin n_fail++; $display("FAIL basic_beats: got %0d need multiple of 4 >= 8", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_data[i] !== base + DW'(i) || obs_last[i] !== (i % 4 == 3)) begin
        n_fail++; $display("FAIL basic_beat%0d: got d=%h l=%b need d=%h l=%b", i, obs_data[i], obs_last[i], base + DW'(i), (i % 4 == 3));
      end
    end
    for (int i = 1; i < 8 && i < n; i++) begin
      n_checks++; if (obs_cyc[i] != obs_cyc[0] + i) begin n_fail++; $display("FAIL basic_bubble%0d: got cycle %0d need %0d", i, obs_cyc[i], obs_cyc[0] + i); end
    end
    n_checks++; if (pkt_count - pc0 !== 32'(n / 4)) begin n_fail++; $display("FAIL basic_pkt_count: got %0d need %0d", pkt_count - pc0, n / 4); end
    exp_base += DW'(n);
  endtask

  task automatic test_full();
    bit ok; int n; logic [31:0] pc0; logic [DW-1:0] base;
    clear_obs(); base = exp_base; pc0 = pkt_count;
    len = 16'd3; axis.tready = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (level !== 3'd4 || axis.tvalid !== 1'b1 || axis.tdata !== base) begin
        n_fail++; $display("FAIL full_hold%0d: got lvl=%0d v=%b d=%h need lvl=4 v=1 d=%h", c, level, axis.tvalid, axis.tdata, base);
      end
    end
    @(posedge clk); #1 axis.tready = 1'b1;
    wait_beats(12, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_wait: got %0d beats need 12", obs_data.size()); end
    #1 enable = 1'b0;
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain: got busy need idle"); end
    n = obs_data.size();
    n_checks++; if (n % 3 != 0) begin n_fail++; $display("FAIL full_beats: got %0d need multiple of 3", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_data[i] !== base + DW'(i) || obs_last[i] !== (i % 3 == 2)) begin
        n_fail++; $display("FAIL full_beat%0d: got d=%h l=%b need d=%h l=%b", i, obs_data[i], obs_last[i], base + DW'(i), (i % 3 == 2));
      end
    end
    n_checks++; if (pkt_count - pc0 !== 32'(n / 3)) begin n_fail++; $display("FAIL full_pkt_count: got %0d need %0d", pkt_count - pc0, n / 3); end
    exp_base += DW'(n);
  endtask

  task automatic test_finish();
    bit ok; logic [DW-1:0] base;
    clear_obs(); base = exp_base;
    len = 16'd5; axis.tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(2, ok);
    #1 enable = 1'b0;
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL finish_drain: got busy need idle"); end
    n_checks++; if (obs_data.size() != 5) begin n_fail++; $display("FAIL finish_beats: got %0d need 5", obs_data.size()); end
    for (int i = 0; i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== base + DW'(i) || obs_last[i] !== (i == 4)) begin
        n_fail++; $display("FAIL finish_beat%0d: got d=%h l=%b need d=%h l=%b", i, obs_data[i], obs_last[i], base + DW'(i), (i == 4));
      end
    end
    exp_base += DW'(obs_data.size());
  endtask

  task automatic test_len_change();
    bit ok; int n; logic [DW-1:0] base; logic exp_l;
    clear_obs(); base = exp_base;
    len = 16'd3; axis.tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(1, ok);
    #1 len = 16'd6;
    wait_beats(15, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lenchg_wait: got %0d beats need 15", obs_data.size()); end
    #1 enable = 1'b0;
    drain(ok);
    n = obs_data.size();
    n_checks++; if (n < 9 || (n - 3) % 6 != 0) begin n_fail++; $display("FAIL lenchg_beats: got %0d need 3+6k", n); end
    for (int i = 0; i < n; i++) begin
      exp_l = (i == 2) || (i >= 3 && (i - 3) % 6 == 5);
      n_checks++;
      if (obs_data[i] !== base + DW'(i) || obs_last[i] !== exp_l) begin
        n_fail++; $display("FAIL lenchg_beat%0d: got d=%h l=%b need d=%h l=%b", i, obs_data[i], obs_last[i], base + DW'(i), exp_l);
      end
    end
    exp_base += DW'(n);
  endtask

  task automatic test_random();
    bit ok; int n, plen; logic [DW-1:0] base;
    logic prev_stall; logic [DW-1:0] prev_d; logic prev_l;
    for (int r = 0; r < 4; r++) begin
      clear_obs(); base = exp_base;
      len = LW'($urandom_range(0, 4));
      plen = (len == 0) ? 1 : int'(len);
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      @(posedge clk); #1 enable = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1 axis.tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (prev_stall) begin
          n_checks++;
          if (axis.tvalid !== 1'b1 || axis.tdata !== prev_d || axis.tlast !== prev_l) begin
            n_fail++; $display("FAIL rand_stall_hold: got v=%b d=%h l=%b need v=1 d=%h l=%b", axis.tvalid, axis.tdata, axis.tlast, prev_d, prev_l);
          end
        end
        n_checks++;
        if (axis.tvalid !== (level != 0) || axis.tstrb !== (axis.tvalid ? 4'hF : 4'h0) || level > 3'd4) begin
          n_fail++; $display("FAIL rand_status: got v=%b s=%h lvl=%0d need v=(lvl!=0) s=F/0 lvl<=4", axis.tvalid, axis.tstrb, level);
        end
        prev_stall = axis.tvalid && !axis.tready;
        prev_d = axis.tdata; prev_l = axis.tlast;
      end
      @(posedge clk); #1 enable = 1'b0;
      drain(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_drain: got busy need idle"); end
      n = obs_data.size();
      n_checks++; if (n == 0 || n % plen != 0) begin n_fail++; $display("FAIL rand_beats: got %0d need nonzero multiple of %0d", n, plen); end
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (obs_data[i] !== base + DW'(i) || obs_last[i] !== (i % plen == plen - 1)) begin
          n_fail++; $display("FAIL rand_beat%0d: got d=%h l=%b need d=%h l=%b", i, obs_data[i], obs_last[i], base + DW'(i), (i % plen == plen - 1));
        end
      end
      exp_base += DW'(n);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; bit hit = 1'b0;
    clear_obs(); len = 16'd8; axis.tready = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      if (level === 3'd3) hit = 1'b1;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_level3: got %0d need 3", level); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || axis.tstrb !== 4'h0 || level !== 3'd0 || pkt_count !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v=%b l=%b s=%h lvl=%0d pc=%0d need all 0", axis.tvalid, axis.tlast, axis.tstrb, level, pkt_count);
    end
    repeat (2) @(posedge clk);
    clear_obs(); exp_base = '0;
    #1 rst_n = 1'b1; axis.tready = 1'b1;
    wait_beats(1, ok);
    n_checks++; if (!ok || obs_data[0] !== 32'h0) begin n_fail++; $display("FAIL rstmid_restart: got %0d beats first=%h need first=0", obs_data.size(), ok ? obs_data[0] : 32'hx); end
    #1 enable = 1'b0;
    drain(ok);
    exp_base += DW'(obs_data.size());
  endtask

`ifdef AXIS_PATTERN_LFSR_EN
  task automatic test_lfsr();
    bit ok; logic [DW-1:0] exp_v[3];
    exp_v[0] = 32'h0000_0001; exp_v[1] = 32'h8020_0002; exp_v[2] = 32'h4010_0001;
    apply_reset();
    mode = 1'b1; len = 16'd4; axis.tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(3, ok);
    #1 enable = 1'b0;
    drain(ok);
    n_checks++; if (obs_data.size() != 4) begin n_fail++; $display("FAIL lfsr_beats: got %0d need 4", obs_data.size()); end
    for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
      n_checks++; if (obs_data[i] !== exp_v[i]) begin n_fail++; $display("FAIL lfsr_beat%0d: got %h need %h", i, obs_data[i], exp_v[i]); end
    end
    mode = 1'b0;
  endtask
`endif

  initial begin
    axis.tready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_finish();
    test_len_change();
    test_random();
    test_reset_mid();
`ifdef AXIS_PATTERN_LFSR_EN
    test_lfsr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

Parametrised AXI4-Stream test-pattern source with integrated buffering: a packetising pattern generator feeds an internal synchronous FIFO whose read side is the m00 AXI-Stream master. It generalises the fixed generator-plus-FIFO pair with runtime packet length, a selectable counter/LFSR pattern, clean packet-boundary stop and status outputs. It sits at the head of lab datapaths as the stimulus for downstream AXI-Stream blocks.

## Interface
- DATA_SIZE, 32: tdata width; multiple of 8, ≥ 8
- ADDR_WIDTH, 12: FIFO depth = 2^ADDR_WIDTH beats
- LEN_WIDTH, 16: width of cfg_pkt_len
- LFSR_SEED, 32'h0000_0001: LFSR reset state; 0 is replaced by 1
- m00_axis_aclk  in  1  sole clock, rising edge
- m00_axis_aresetn  in  1  asynchronous active-low reset
- m00_axis_enable  in  1  run request
- cfg_mode  in  1  0 = counter, 1 = LFSR; latched at packet start
- cfg_pkt_len  in  LEN_WIDTH  beats per packet; latched at packet start; 0 treated as 1
- m00_axis_tready  in  1  downstream ready
- m00_axis_tdata  out  DATA_SIZE  beat data
- m00_axis_tstrb  out  DATA_SIZE/8  all ones while tvalid, else 0
- m00_axis_tvalid  out  1  FIFO not empty
- m00_axis_tlast  out  1  last beat of packet
- fifo_level  out  ADDR_WIDTH+1  beats stored, 0..2^ADDR_WIDTH
- pkt_count  out  32  packets fully accepted downstream, wraps

## Operation
- Generator FSM: IDLE, RUN, FINISH.
  - IDLE: enable=1 → RUN, latch cfg_mode/cfg_pkt_len, beat index 0.
  - RUN: one beat written per cycle while FIFO not full; last beat of packet written with tlast=1; then enable=1 → relatch config, stay RUN; enable=0 → IDLE.
  - RUN with enable=0 mid-packet → FINISH: packet completed, then IDLE. Packets never truncated.
- Counter pattern: DATA_SIZE-bit counter, +1 per written beat, wraps at 2^DATA_SIZE; persists across packets and idle periods; cleared only by reset.
- LFSR pattern: 32-bit Galois, polynomial 0x80200003, advanced once per written beat; tdata = state zero-extended/truncated to DATA_SIZE. Written beat carries the state before advancing.
- Full: write suppressed, generator state, counter and LFSR held. Write gated by registered full; no write when full even if a read occurs that cycle.
- Empty: tvalid=0, tdata/tlast held at last value, tstrb=0.
- Read on tvalid & tready; tdata/tlast stable while tvalid & !tready.
- fifo_level: +1 on write, −1 on read, unchanged on simultaneous.
- pkt_count +1 on tvalid & tready & tlast.
- Reset (any time, including mid-packet): FSM IDLE, FIFO emptied, counter 0, LFSR=seed, all outputs 0, pkt_count 0.

## Timing
- enable sampled 1 at edge 0 → RUN; beat 0 written at edge 1; tvalid=1 after edge 1 (empty FIFO, first-word fall-through).
- Steady state with tready=1: one beat per cycle, no bubbles, including across packet boundaries.
- fifo_level and pkt_count registered; update after the causing edge.
- Config changes mid-packet have no effect until the next packet start.

## Configuration
- AXIS_PATTERN_LFSR_EN defined: LFSR logic built, cfg_mode honoured.
- Undefined: no LFSR logic, cfg_mode ignored, counter pattern always.

## Structure
- Package axis_pattern_pkg: FSM state encodings, mode constants (MODE_COUNTER=0, MODE_LFSR=1), LFSR_POLY=32'h80200003.
- One sub-module: axis_sync_fifo (DATA_SIZE+1 wide for tlast, 2^ADDR_WIDTH deep, FWFT, level output). Generator FSM lives in top.

## Test plan
- Reset, enable=1, len=4, mode=0, tready=1 → tdata 0,1,2,3 with tlast on 3; next packet 4..7; pkt_count=2 after 8 beats.
- ADDR_WIDTH=2, tready=0, enable=1 → fifo_level reaches 4, stays; tdata=0 stable; tready=1 → 0,1,2,3,4… without gaps or duplicates.
- len=5, enable dropped after 2 beats → exactly 5 beats, tlast on 5th, then no writes.
- Change cfg_pkt_len 3→6 mid-packet → current packet 3 beats, next 6.
- AXIS_PATTERN_LFSR_EN, mode=1, seed 1 → tdata 1, 0x80200002, 0x40100001 (DATA_SIZE=32).
- Reset asserted mid-packet with FIFO at level 3 → tvalid, tlast, tstrb, fifo_level, pkt_count all 0 immediately; restart begins at tdata 0.
